// File: rtl/frame_loader.sv
// rtl/frame_loader.sv - double-buffered pixel frame loader for a split-scan LED panel
// Streams pixels into the hidden bank in raster order; scan reads both half-panel rows from the shown bank.
module frame_loader #(
  parameter int COLS  = 64,
  parameter int ROWS  = 32,
  parameter int CBITS = 3,
  localparam int XW   = $clog2(COLS),
  localparam int YW   = $clog2(ROWS),
  localparam int RYW  = YW - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [CBITS-1:0] s_data,
  input  logic             s_sof,
  input  logic             frame_done,
  input  logic [XW-1:0]    rd_x,
  input  logic [RYW-1:0]   rd_y,
  output logic [CBITS-1:0] rd_c1,
  output logic [CBITS-1:0] rd_c2,
  output logic             frame_pending,
  output logic             sync_err,
  output logic [7:0]       drop_cnt
);

  localparam int AW    = 1 + RYW + XW;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

  state_t           state, state_next;
  logic             disp_bank;
  logic [XW-1:0]    wx;
  logic [YW-1:0]    wy;

  logic             accept;
  logic             wr_en;
  logic [XW-1:0]    wr_x;
  logic [YW-1:0]    wr_y;
  logic             ptr_restart;
  logic             ptr_inc;
  logic             drop_inc;
  logic             sync_set;
  logic             swap;
  logic             last_px;

  // Upper and lower half-panel rows live in separate arrays so both are read in one cycle.
  logic [CBITS-1:0] mem_hi [DEPTH];
  logic [CBITS-1:0] mem_lo [DEPTH];

  assign accept        = s_valid && s_ready;
  assign last_px       = (wx == XW'(COLS - 1)) && (wy == YW'(ROWS - 1));
  assign frame_pending = (state == FULL);

  always_comb begin
    state_next  = state;
    wr_en       = 1'b0;
    wr_x        = '0;
    wr_y        = '0;
    ptr_restart = 1'b0;
    ptr_inc     = 1'b0;
    drop_inc    = 1'b0;
    sync_set    = 1'b0;
    swap        = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (s_sof) begin
            wr_en       = 1'b1;
            ptr_restart = 1'b1;
            state_next  = LOAD;
          end else begin
            drop_inc = 1'b1;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          wr_en = 1'b1;
          if (s_sof) begin
            sync_set    = 1'b1;
            ptr_restart = 1'b1;
          end else begin
            wr_x    = wx;
            wr_y    = wy;
            ptr_inc = 1'b1;
            if (last_px) state_next = FULL;
          end
        end
      end
      FULL: begin
        if (frame_done) begin
          swap       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      s_ready   <= 1'b0;
      disp_bank <= 1'b0;
      sync_err  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      state   <= state_next;
      s_ready <= (state_next != FULL);
      if (swap) disp_bank <= ~disp_bank;
      if (sync_set) sync_err <= 1'b1;
      if (drop_inc && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Write pointer names the pixel after the one just written.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wx <= '0;
      wy <= '0;
    end else if (ptr_restart) begin
      wx <= XW'(1);
      wy <= '0;
    end else if (ptr_inc) begin
      if (wx == XW'(COLS - 1)) begin
        wx <= '0;
        wy <= (wy == YW'(ROWS - 1)) ? '0 : wy + YW'(1);
      end else begin
        wx <= wx + XW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_y[YW-1]) mem_lo[{~disp_bank, wr_y[RYW-1:0], wr_x}] <= s_data;
      else            mem_hi[{~disp_bank, wr_y[RYW-1:0], wr_x}] <= s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_c1 <= '0;
      rd_c2 <= '0;
    end else begin
      rd_c1 <= mem_hi[{disp_bank, rd_y, rd_x}];
      rd_c2 <= mem_lo[{disp_bank, rd_y, rd_x}];
    end
  end

endmodule
